cci_mpf_active_tracker: RTL and testbench
=========================================

Name: cci_mpf_active_tracker

Overview:
- Parametrised per-channel outstanding-request tracker that generalises MPF's fixed two-channel NotEmpty counters.
- Counts active lines per channel, including multi-line requests and responses, and drives a registered almost-full signal toward the AFU.
- Flags counter underflow and overflow as sticky errors.
- Provides a drain handshake that stalls new traffic and acknowledges once every channel is idle.
- Sits at the AFU edge of the MPF pipeline, next to the CSR shim.

Parameters:
- N_CHANNELS, 2, number of independently tracked channels (1..8).
- MAX_ACTIVE, 1024, per-channel active-line limit; must be a power of 2.
- AF_SLACK, 8, almost_full asserts when count + AF_SLACK >= MAX_ACTIVE.
- CW, $clog2(MAX_ACTIVE)+1, counter width (derived; do not override).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_CHANNELS  request accepted on channel i this cycle.
- req_len  in  2*N_CHANNELS  lines minus 1 for channel i's request (0..3 encodes 1..4 lines).
- rsp_valid  in  N_CHANNELS  response retired on channel i this cycle.
- rsp_len  in  2*N_CHANNELS  lines minus 1 retired by channel i's response.
- drain_req  in  1  level request to quiesce all channels.
- drain_ack  out  1  all channels idle while draining.
- not_empty  out  N_CHANNELS  channel has active lines.
- almost_full  out  N_CHANNELS  throttle new requests.
- active_cnt  out  CW*N_CHANNELS  current line count per channel.
- err_underflow  out  N_CHANNELS  sticky underflow error.
- err_overflow  out  N_CHANNELS  sticky overflow error.

Behaviour:
- Reset values: all counts 0; not_empty, almost_full, drain_ack and both error vectors 0; FSM in IDLE.
- Per channel, each cycle:
  - inc = req_valid ? req_len+1 : 0.
  - dec = rsp_valid ? rsp_len+1 : 0.
  - nxt = cnt + inc - dec, computed at CW+1 bits signed.
- Underflow: if nxt < 0, cnt <= 0 and err_underflow[i] <= 1.
- Overflow: if nxt > 2^CW-1, cnt <= 2^CW-1 and err_overflow[i] <= 1.
- Error bits clear only on reset.
- Simultaneous request and response on one channel: net arithmetic in the same cycle. Equal inc and dec leaves the count unchanged.
- All outputs are registered with 1-cycle latency from the inputs:
  - active_cnt shows the updated count the cycle after the event.
  - not_empty <= (updated cnt != 0).
  - almost_full <= (updated cnt + AF_SLACK >= MAX_ACTIVE) OR (next FSM state is DRAINING or DRAINED).
- Drain FSM, shared across all channels:
  - IDLE: drain_req=1 moves to DRAINING.
  - DRAINING: almost_full forced to 1 on all channels. Requests that still arrive are counted normally, since the AFU may take up to AF_SLACK cycles to react. When every updated cnt == 0 and req_valid == 0, move to DRAINED.
  - DRAINED: drain_ack=1 (registered, asserted the cycle the state is entered). Stays here while drain_req=1. drain_req=0 returns to IDLE with drain_ack=0 on the next cycle.
  - A request arriving while in DRAINED is counted and sets err_overflow? No: it is counted normally. The FSM stays in DRAINED until drain_req drops.
  - drain_req dropped while DRAINING returns to IDLE immediately; drain_ack is never asserted in that case.
- Reset mid-drain: FSM returns to IDLE and all counts are zeroed in the same cycle.

Optional Feature:
- Macro: MPF_ACTIVE_TRACKER_HWM_EN.
- When defined, adds output hwm (CW*N_CHANNELS) and input hwm_clear (1).
  - hwm[i] <= max(hwm[i], updated cnt[i]) every cycle.
  - hwm_clear=1 loads hwm[i] with the updated cnt[i].
  - Reset value of hwm is 0.
- When undefined, both ports and the registers are absent and all other behaviour is identical.

Test Plan:
- Channel 0 sees req len=3 at cycle 1 and rsp len=0 at cycles 3,4,5,6 -> active_cnt[0] reads 4 at cycle 2, reads 0 after cycle 7; not_empty[0] deasserts in the cycle after cycle 6.
- MAX_ACTIVE=16, AF_SLACK=4: 12 single-line requests -> almost_full[0]=1 the cycle after the 12th; one response -> almost_full deasserts next cycle (count 11).
- Same cycle on channel 1: req len=1 and rsp len=1 with cnt=5 -> cnt stays 5; no error flags.
- rsp len=2 with cnt=1 -> cnt=0 and err_underflow=1; the flag persists through subsequent traffic until reset.
- drain_req=1 with channel 0 cnt=2 and channel 1 cnt=0 -> all almost_full=1 the next cycle; drain_ack rises the cycle after the last response; drain_req=0 -> drain_ack=0 and almost_full back to threshold-based.
- With MPF_ACTIVE_TRACKER_HWM_EN: ramp cnt to 9, then back to 2 -> hwm=9; hwm_clear -> hwm=2.

Source files
------------

// File: rtl/cci_mpf_active_tracker.sv
// Per-channel outstanding-line tracker with registered almost-full, sticky
// under/overflow flags and a shared drain handshake. Optional high-water marks
// are enabled by defining MPF_ACTIVE_TRACKER_HWM_EN.
module cci_mpf_active_tracker #(
  parameter int N_CHANNELS = 2,
  parameter int MAX_ACTIVE = 1024,
  parameter int AF_SLACK   = 8,
  parameter int CW         = $clog2(MAX_ACTIVE) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef MPF_ACTIVE_TRACKER_HWM_EN
  input  logic                     hwm_clear,
  output logic [CW*N_CHANNELS-1:0] hwm,
`endif
  input  logic [N_CHANNELS-1:0]    req_valid,
  input  logic [2*N_CHANNELS-1:0]  req_len,
  input  logic [N_CHANNELS-1:0]    rsp_valid,
  input  logic [2*N_CHANNELS-1:0]  rsp_len,
  input  logic                     drain_req,
  output logic                     drain_ack,
  output logic [N_CHANNELS-1:0]    not_empty,
  output logic [N_CHANNELS-1:0]    almost_full,
  output logic [CW*N_CHANNELS-1:0] active_cnt,
  output logic [N_CHANNELS-1:0]    err_underflow,
  output logic [N_CHANNELS-1:0]    err_overflow
);

  // Two guard bits: one for the sign, one so a saturated count plus a
  // 4-line request still compares above the counter maximum.
  localparam int XW = CW + 2;
  localparam logic signed [XW-1:0] CNT_MAX_C = XW'({CW{1'b1}});

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAINING = 2'd1,
    ST_DRAINED  = 2'd2
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [CW-1:0]           cnt_r   [N_CHANNELS];
  logic [CW-1:0]           upd_s   [N_CHANNELS];
  logic signed [XW-1:0]    inc_s   [N_CHANNELS];
  logic signed [XW-1:0]    dec_s   [N_CHANNELS];
  logic signed [XW-1:0]    nxt_s   [N_CHANNELS];
  logic [N_CHANNELS-1:0]   uf_set_s;
  logic [N_CHANNELS-1:0]   of_set_s;
  logic [N_CHANNELS-1:0]   af_thr_s;
  logic                    all_idle_s;
  logic                    drain_force_s;

  // Per-channel net update with saturation and error detection.
  always_comb begin
    uf_set_s   = {N_CHANNELS{1'b0}};
    of_set_s   = {N_CHANNELS{1'b0}};
    af_thr_s   = {N_CHANNELS{1'b0}};
    all_idle_s = 1'b1;
    for (int i = 0; i < N_CHANNELS; i++) begin
      inc_s[i] = req_valid[i] ? (XW'(req_len[2*i +: 2]) + XW'(1)) : {XW{1'b0}};
      dec_s[i] = rsp_valid[i] ? (XW'(rsp_len[2*i +: 2]) + XW'(1)) : {XW{1'b0}};
      nxt_s[i] = $signed(XW'(cnt_r[i])) + inc_s[i] - dec_s[i];
      if (nxt_s[i][XW-1]) begin
        upd_s[i]    = {CW{1'b0}};
        uf_set_s[i] = 1'b1;
      end else if (nxt_s[i] > CNT_MAX_C) begin
        upd_s[i]    = {CW{1'b1}};
        of_set_s[i] = 1'b1;
      end else begin
        upd_s[i]    = nxt_s[i][CW-1:0];
      end
      af_thr_s[i] = (32'(upd_s[i]) + 32'(AF_SLACK)) >= 32'(MAX_ACTIVE);
      if (upd_s[i] != {CW{1'b0}}) begin
        all_idle_s = 1'b0;
      end else begin
        all_idle_s = all_idle_s;
      end
    end
  end

  // Drain FSM next state; a dropped drain_req always returns to IDLE.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (drain_req) state_nxt_s = ST_DRAINING;
        else           state_nxt_s = ST_IDLE;
      end
      ST_DRAINING: begin
        if (!drain_req)                                               state_nxt_s = ST_IDLE;
        else if (all_idle_s && (req_valid == {N_CHANNELS{1'b0}}))     state_nxt_s = ST_DRAINED;
        else                                                          state_nxt_s = ST_DRAINING;
      end
      ST_DRAINED: begin
        if (drain_req) state_nxt_s = ST_DRAINED;
        else           state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
    drain_force_s = (state_nxt_s == ST_DRAINING) || (state_nxt_s == ST_DRAINED);
  end

  // Counters, FSM state and all registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      drain_ack     <= 1'b0;
      not_empty     <= {N_CHANNELS{1'b0}};
      almost_full   <= {N_CHANNELS{1'b0}};
      err_underflow <= {N_CHANNELS{1'b0}};
      err_overflow  <= {N_CHANNELS{1'b0}};
      for (int i = 0; i < N_CHANNELS; i++) cnt_r[i] <= {CW{1'b0}};
    end else begin
      state_r       <= state_nxt_s;
      drain_ack     <= (state_nxt_s == ST_DRAINED);
      almost_full   <= af_thr_s | {N_CHANNELS{drain_force_s}};
      err_underflow <= err_underflow | uf_set_s;
      err_overflow  <= err_overflow | of_set_s;
      for (int i = 0; i < N_CHANNELS; i++) begin
        cnt_r[i]     <= upd_s[i];
        not_empty[i] <= (upd_s[i] != {CW{1'b0}});
      end
    end
  end

  // Flatten the counter array onto the packed output bus.
  always_comb begin
    active_cnt = {CW*N_CHANNELS{1'b0}};
    for (int i = 0; i < N_CHANNELS; i++) active_cnt[i*CW +: CW] = cnt_r[i];
  end

`ifdef MPF_ACTIVE_TRACKER_HWM_EN
  logic [CW-1:0] hwm_r [N_CHANNELS];

  // High-water mark tracks the post-update count; clear reloads it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CHANNELS; i++) hwm_r[i] <= {CW{1'b0}};
    end else begin
      for (int i = 0; i < N_CHANNELS; i++) begin
        if (hwm_clear || (upd_s[i] > hwm_r[i])) hwm_r[i] <= upd_s[i];
        else                                    hwm_r[i] <= hwm_r[i];
      end
    end
  end

  // Flatten the high-water marks onto the packed output bus.
  always_comb begin
    hwm = {CW*N_CHANNELS{1'b0}};
    for (int i = 0; i < N_CHANNELS; i++) hwm[i*CW +: CW] = hwm_r[i];
  end
`endif

endmodule

// File: tb/tb_cci_mpf_active_tracker.sv
// Scoreboard bench: a behavioural model predicts every registered output when
// stimulus is driven; the prediction is popped and compared one cycle later.
module tb_cci_mpf_active_tracker;

  localparam int NC  = 2;
  localparam int MA  = 16;
  localparam int AS  = 4;
  localparam int CW  = 5;
  localparam int MAXC = 31;

  logic              clk = 1'b0;
  logic              reset;
  logic [NC-1:0]     req_valid, rsp_valid;
  logic [2*NC-1:0]   req_len, rsp_len;
  logic              drain_req, drain_ack;
  logic [NC-1:0]     not_empty, almost_full, err_underflow, err_overflow;
  logic [CW*NC-1:0]  active_cnt;
  logic              hwm_clear;
  logic [CW*NC-1:0]  hwm;

  always #5 clk = ~clk;

  cci_mpf_active_tracker #(
    .N_CHANNELS(NC), .MAX_ACTIVE(MA), .AF_SLACK(AS)
  ) dut (
    .clk(clk), .reset(reset),
`ifdef MPF_ACTIVE_TRACKER_HWM_EN
    .hwm_clear(hwm_clear), .hwm(hwm),
`endif
    .req_valid(req_valid), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_len(rsp_len),
    .drain_req(drain_req), .drain_ack(drain_ack),
    .not_empty(not_empty), .almost_full(almost_full),
    .active_cnt(active_cnt),
    .err_underflow(err_underflow), .err_overflow(err_overflow)
  );

  typedef struct packed {
    logic [CW*NC-1:0] cnt;
    logic [NC-1:0]    ne, af, uf, of;
    logic             ack;
    logic [CW*NC-1:0] hwm;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  int   m_cnt [NC];
  int   m_hwm [NC];
  logic [NC-1:0] m_uf = '0, m_of = '0;
  int   m_st = 0;
  logic drq = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [NC-1:0] rv, input logic [2*NC-1:0] rl,
                      input logic [NC-1:0] sv, input logic [2*NC-1:0] sl,
                      input logic hclr, input logic rst);
    exp_t e;
    int   n, inc, dec, ns;
    bit   allz;
    req_valid = rv; req_len = rl; rsp_valid = sv; rsp_len = sl;
    drain_req = drq; hwm_clear = hclr; reset = rst;
    e = '0;
    if (rst) begin
      for (int i = 0; i < NC; i++) begin m_cnt[i] = 0; m_hwm[i] = 0; end
      m_uf = '0; m_of = '0; m_st = 0;
    end else begin
      allz = 1'b1;
      for (int i = 0; i < NC; i++) begin
        inc = rv[i] ? int'(rl[2*i +: 2]) + 1 : 0;
        dec = sv[i] ? int'(sl[2*i +: 2]) + 1 : 0;
        n = m_cnt[i] + inc - dec;
        if (n < 0)         begin n = 0;    m_uf[i] = 1'b1; end
        else if (n > MAXC) begin n = MAXC; m_of[i] = 1'b1; end
        m_cnt[i] = n;
        if (n != 0) allz = 1'b0;
        if (hclr || n > m_hwm[i]) m_hwm[i] = n;
      end
      case (m_st)
        0:       ns = drq ? 1 : 0;
        1:       ns = !drq ? 0 : ((allz && rv == '0) ? 2 : 1);
        2:       ns = drq ? 2 : 0;
        default: ns = 0;
      endcase
      m_st = ns;
      for (int i = 0; i < NC; i++) begin
        e.cnt[i*CW +: CW] = CW'(m_cnt[i]);
        e.ne[i]           = (m_cnt[i] != 0);
        e.af[i]           = (m_cnt[i] + AS >= MA) || (ns != 0);
        e.hwm[i*CW +: CW] = CW'(m_hwm[i]);
      end
      e.uf  = m_uf;
      e.of  = m_of;
      e.ack = (ns == 2);
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk("active_cnt",    32'(active_cnt),    32'(e.cnt));
      chk("not_empty",     32'(not_empty),     32'(e.ne));
      chk("almost_full",   32'(almost_full),   32'(e.af));
      chk("err_underflow", 32'(err_underflow), 32'(e.uf));
      chk("err_overflow",  32'(err_overflow),  32'(e.of));
      chk("drain_ack",     32'(drain_ack),     32'(e.ack));
`ifdef MPF_ACTIVE_TRACKER_HWM_EN
      chk("hwm",           32'(hwm),           32'(e.hwm));
`endif
    end
  endtask

  task automatic idle();
    step('0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic req(input int ch, input int len);
    step(NC'(1) << ch, (2*NC)'(len) << (2*ch), '0, '0, 1'b0, 1'b0);
  endtask

  task automatic rsp(input int ch, input int len);
    step('0, '0, NC'(1) << ch, (2*NC)'(len) << (2*ch), 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < NC; i++) begin m_cnt[i] = 0; m_hwm[i] = 0; end
    hwm_clear = 1'b0;
    step('0, '0, '0, '0, 1'b0, 1'b1);
    step('0, '0, '0, '0, 1'b0, 1'b1);

    // 4-line request retired by four single-line responses
    req(0, 3); idle();
    for (int k = 0; k < 4; k++) rsp(0, 0);
    idle();

    // almost_full threshold at count 12 with MAX_ACTIVE=16, AF_SLACK=4
    for (int k = 0; k < 12; k++) req(0, 0);
    rsp(0, 0);
    rsp(0, 3); rsp(0, 3); rsp(0, 2);

    // simultaneous equal request/response leaves count unchanged
    req(1, 3); req(1, 0);
    step(2'b10, 4'b0100, 2'b10, 4'b0100, 1'b0, 1'b0);
    // underflow then persistence
    rsp(1, 3); rsp(1, 2);
    req(1, 1); rsp(1, 1); idle();

    // full drain handshake, request seen while drained
    req(0, 1);
    drq = 1'b1;
    idle(); rsp(0, 0); rsp(0, 0); idle(); idle();
    req(1, 0); rsp(1, 0); idle();
    drq = 1'b0;
    idle(); idle();

    // drain aborted while still draining
    drq = 1'b1; req(0, 0); idle();
    drq = 1'b0; idle(); rsp(0, 0);

    // overflow saturation
    for (int k = 0; k < 9; k++) step(2'b11, 4'b1111, 2'b10, 4'b0000, 1'b0, 1'b0);
    rsp(0, 3); idle();

    // reset mid-drain
    drq = 1'b1; idle(); idle();
    step('0, '0, '0, '0, 1'b0, 1'b1);
    drq = 1'b0; idle();

    // high-water mark ramp to 9, down to 2, then clear
    req(0, 2); req(0, 2); req(0, 2);
    rsp(0, 3); rsp(0, 2); idle();
    step('0, '0, '0, '0, 1'b1, 1'b0); idle();

    // random traffic with occasional drain toggles, clears and resets
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 15) == 0) drq = ~drq;
      step(NC'($urandom), (2*NC)'($urandom), NC'($urandom), (2*NC)'($urandom),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 63) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
